packet_tx_arbiter: RTL and testbench

Shares the single serial TX byte stream between two packet-producing requesters, for example the debug/DMA response path and the CPU print path. Each packet is sent whole and framed as magic byte 0x51, then a 16-bit big-endian payload length, then the payload bytes. This is the same framing the RX side parses into packets, so a host sees one well-formed packet stream. Arbitration is round-robin and packet-atomic: a grant is never revoked until the packet's last byte is accepted.

---
 rtl/packet_tx_arbiter_if.sv | 42 ++++
 rtl/packet_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_packet_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_tx_arbiter_if.sv
// Bundle of the two requester ports, the serial TX byte stream and status
// shared between the packet arbiter (master) and its environment (slave).
interface packet_tx_arbiter_if;
    logic        req0_valid;
    logic [15:0] req0_length;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req0_done;

    logic        req1_valid;
    logic [15:0] req1_length;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic        req1_done;

    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    logic [1:0]  grant;
    logic        busy;

    modport master (
        input  req0_valid, req0_length, req0_data,
        output req0_ready, req0_done,
        input  req1_valid, req1_length, req1_data,
        output req1_ready, req1_done,
        output out_valid, out_data,
        input  out_ready,
        output grant, busy
    );

    modport slave (
        output req0_valid, req0_length, req0_data,
        input  req0_ready, req0_done,
        output req1_valid, req1_length, req1_data,
        input  req1_ready, req1_done,
        input  out_valid, out_data,
        output out_ready,
        input  grant, busy
    );
endinterface

// File: rtl/packet_tx_arbiter.sv
// Round-robin, packet-atomic arbiter merging two requesters onto one TX byte
// stream; each packet is framed as MAGIC, 16-bit big-endian length, payload.
module packet_tx_arbiter #(
    parameter logic [7:0] MAGIC = 8'h51
) (
    input  logic                 clock,
    input  logic                 clear_n,
    packet_tx_arbiter_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAGIC,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        owner;
    logic        last_served;
    logic [15:0] remaining;

    logic        any_valid;
    logic        pick;
    logic        owner_valid;
    logic [7:0]  owner_data;
    logic        out_valid_c;
    logic [7:0]  out_data_c;
    logic        ready_c;
    logic        packet_end;
    logic        payload_xfer;

    assign any_valid   = bus.req0_valid | bus.req1_valid;
    assign owner_valid = owner ? bus.req1_valid : bus.req0_valid;
    assign owner_data  = owner ? bus.req1_data  : bus.req0_data;

    // A tie goes to whichever requester was not served most recently.
    always_comb begin
        pick = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            pick = ~last_served;
        end else if (bus.req1_valid) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        next_state   = state;
        out_valid_c  = 1'b0;
        out_data_c   = 8'h00;
        ready_c      = 1'b0;
        packet_end   = 1'b0;
        payload_xfer = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    next_state = ST_MAGIC;
                end
            end
            ST_MAGIC: begin
                out_valid_c = 1'b1;
                out_data_c  = MAGIC;
                if (bus.out_ready) begin
                    next_state = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                out_valid_c = 1'b1;
                out_data_c  = remaining[15:8];
                if (bus.out_ready) begin
                    next_state = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                out_valid_c = 1'b1;
                out_data_c  = remaining[7:0];
                if (bus.out_ready) begin
                    if (remaining == 16'd0) begin
                        packet_end = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                out_valid_c  = owner_valid;
                out_data_c   = owner_data;
                ready_c      = bus.out_ready;
                payload_xfer = owner_valid & bus.out_ready;
                if (payload_xfer && remaining == 16'd1) begin
                    packet_end = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Header bytes are read back from the latched count; it only starts
    // counting down once payload bytes move.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            remaining   <= 16'd0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && any_valid) begin
                owner     <= pick;
                remaining <= pick ? bus.req1_length : bus.req0_length;
            end else if (payload_xfer) begin
                remaining <= remaining - 16'd1;
            end
            if (packet_end) begin
                last_served <= owner;
            end
        end
    end

    assign bus.out_valid  = out_valid_c;
    assign bus.out_data   = out_data_c;
    assign bus.req0_ready = ready_c & ~owner;
    assign bus.req1_ready = ready_c & owner;
    assign bus.req0_done  = packet_end & ~owner;
    assign bus.req1_done  = packet_end & owner;
    assign bus.grant      = (state == ST_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Randomised bench for packet_tx_arbiter: requester packets are queued, the
// expected framed byte stream is derived from the queues, and compared.
module tb_packet_tx_arbiter;

    logic clock = 1'b0;
    logic clear_n;
    always #5 clock = ~clock;

    packet_tx_arbiter_if bus();

    packet_tx_arbiter dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    int checks = 0;
    int passed = 0;

    int          q_len0[$];
    int          q_len1[$];
    logic [7:0]  q_dat0[$];
    logic [7:0]  q_dat1[$];
    int          idx0, idx1;
    int          model_last;

    // Observed/expected word: {grant, req1_done, req0_done, out_data}
    logic [11:0] obs_word[$];
    int          obs_cycle[$];
    logic [11:0] exp_word[$];
    int          exp_cycle[$];
    int          proto_errs, stall_errs;
    int          ready_cnt0, ready_cnt1, done_cnt0, done_cnt1, accepted;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_requesters();
        q_len0.delete(); q_len1.delete();
        q_dat0.delete(); q_dat1.delete();
        idx0 = 0; idx1 = 0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Whole-packet model: pending packets are served round-robin, each
    // framed as 51, len_hi, len_lo, payload, with one idle cycle between.
    task automatic build_expected();
        int         l0[$] = q_len0;
        int         l1[$] = q_len1;
        logic [7:0] d0[$] = q_dat0;
        logic [7:0] d1[$] = q_dat1;
        int         t = 0;
        int         r;
        int         len;
        logic [1:0] g;
        logic [7:0] b;
        exp_word.delete();
        exp_cycle.delete();
        while (l0.size() > 0 || l1.size() > 0) begin
            if (l0.size() > 0 && l1.size() > 0) r = (model_last == 1) ? 0 : 1;
            else r = (l0.size() > 0) ? 0 : 1;
            len = (r == 0) ? l0.pop_front() : l1.pop_front();
            g = (r == 0) ? 2'b01 : 2'b10;
            t++; exp_word.push_back({g, 2'b00, 8'h51}); exp_cycle.push_back(t);
            t++; exp_word.push_back({g, 2'b00, 8'(len >> 8)}); exp_cycle.push_back(t);
            t++; exp_word.push_back({g, (len == 0) ? g : 2'b00, 8'(len)}); exp_cycle.push_back(t);
            for (int i = 0; i < len; i++) begin
                b = (r == 0) ? d0.pop_front() : d1.pop_front();
                t++;
                exp_word.push_back({g, (i == len - 1) ? g : 2'b00, b});
                exp_cycle.push_back(t);
            end
            t++;
            model_last = r;
        end
    endtask

    task automatic run_traffic(input int max_cycles, input int ready_mode, input int gap_pct,
                               input int stop_after, output bit timed_out);
        bit         stalled = 1'b0;
        logic [7:0] stall_data = 8'h00;
        obs_word.delete(); obs_cycle.delete();
        proto_errs = 0; stall_errs = 0; accepted = 0;
        ready_cnt0 = 0; ready_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
        timed_out = 1'b1;
        for (int k = 0; k < max_cycles; k++) begin
            @(negedge clock);
            if (q_len0.size() > 0) begin
                bus.req0_length = 16'(q_len0[0]);
                bus.req0_data   = (q_dat0.size() > 0) ? q_dat0[0] : 8'h00;
                bus.req0_valid  = !(idx0 > 0 && $urandom_range(0, 99) < gap_pct);
            end else begin
                bus.req0_valid = 1'b0;
            end
            if (q_len1.size() > 0) begin
                bus.req1_length = 16'(q_len1[0]);
                bus.req1_data   = (q_dat1.size() > 0) ? q_dat1[0] : 8'h00;
                bus.req1_valid  = !(idx1 > 0 && $urandom_range(0, 99) < gap_pct);
            end else begin
                bus.req1_valid = 1'b0;
            end
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (k % 2 == 0);
                default: bus.out_ready = ($urandom_range(0, 99) < 70);
            endcase
            #1;
            if (bus.grant == 2'b11) proto_errs++;
            if (bus.req0_ready && bus.grant != 2'b01) proto_errs++;
            if (bus.req1_ready && bus.grant != 2'b10) proto_errs++;
            if ((bus.req0_done || bus.req1_done) && !(bus.out_valid && bus.out_ready)) proto_errs++;
            if (stalled && bus.out_valid && bus.out_data !== stall_data) stall_errs++;
            stalled    = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                obs_word.push_back({bus.grant, bus.req1_done, bus.req0_done, bus.out_data});
                obs_cycle.push_back(k);
            end
            if (bus.req0_ready) ready_cnt0++;
            if (bus.req1_ready) ready_cnt1++;
            if (bus.req0_valid && bus.req0_ready) begin
                if (q_dat0.size() > 0) void'(q_dat0.pop_front());
                idx0++; accepted++;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                if (q_dat1.size() > 0) void'(q_dat1.pop_front());
                idx1++; accepted++;
            end
            if (bus.req0_done) begin
                done_cnt0++; idx0 = 0;
                if (q_len0.size() > 0) void'(q_len0.pop_front());
            end
            if (bus.req1_done) begin
                done_cnt1++; idx1 = 0;
                if (q_len1.size() > 0) void'(q_len1.pop_front());
            end
            if (stop_after >= 0 && accepted >= stop_after) begin
                timed_out = 1'b0;
                break;
            end
            if (stop_after < 0 && q_len0.size() == 0 && q_len1.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (stop_after < 0) begin
            @(posedge clock); #1;
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            bus.out_ready  = 1'b0;
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_length = 16'd4; bus.req0_data = 8'hEE;
        bus.req1_valid = 1'b1; bus.req1_length = 16'd4; bus.req1_data = 8'hDD;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.out_data !== 8'h00) $display("[TB] FAIL reset_out_data: got %h want 00", bus.out_data); else passed++;
        checks++; if (bus.grant !== 2'b00) $display("[TB] FAIL reset_grant: got %b want 00", bus.grant); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) $display("[TB] FAIL reset_ready: got %b want 00", {bus.req1_ready, bus.req0_ready}); else passed++;
        checks++; if ({bus.req1_done, bus.req0_done} !== 2'b00) $display("[TB] FAIL reset_done: got %b want 00", {bus.req1_done, bus.req0_done}); else passed++;
        clear_requesters();
        bus.out_ready = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        model_last = 1;
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL idle_after_reset_busy: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_single();
        bit to;
        clear_requesters();
        q_len0.push_back(3);
        q_dat0.push_back(8'hA1); q_dat0.push_back(8'hA2); q_dat0.push_back(8'hA3);
        build_expected();
        run_traffic(200, 0, 0, -1, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL single_timeout: got %b want 0", to); else passed++;
        checks++; if (obs_word.size() != exp_word.size()) $display("[TB] FAIL single_count: got %0d want %0d", obs_word.size(), exp_word.size()); else passed++;
        for (int i = 0; i < exp_word.size(); i++) begin
            checks++;
            if (i >= obs_word.size() || obs_word[i] !== exp_word[i] || obs_cycle[i] != exp_cycle[i])
                $display("[TB] FAIL single_byte[%0d]: got %h@%0d want %h@%0d", i,
                         (i < obs_word.size()) ? obs_word[i] : 12'hxxx, (i < obs_cycle.size()) ? obs_cycle[i] : -1,
                         exp_word[i], exp_cycle[i]);
            else passed++;
        end
        checks++; if (ready_cnt1 != 0 || done_cnt0 != 1 || proto_errs != 0) $display("[TB] FAIL single_side: got ready1=%0d done0=%0d proto=%0d want 0/1/0", ready_cnt1, done_cnt0, proto_errs); else passed++;
    endtask

    task automatic test_back_to_back();
        bit to;
        clear_requesters();
        q_len0.push_back(2); q_len0.push_back(3);
        q_len1.push_back(1); q_len1.push_back(2);
        for (int i = 0; i < 5; i++) q_dat0.push_back(8'($urandom));
        for (int i = 0; i < 3; i++) q_dat1.push_back(8'($urandom));
        build_expected();
        run_traffic(300, 0, 0, -1, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL b2b_timeout: got %b want 0", to); else passed++;
        checks++; if (obs_word.size() != exp_word.size()) $display("[TB] FAIL b2b_count: got %0d want %0d", obs_word.size(), exp_word.size()); else passed++;
        for (int i = 0; i < exp_word.size(); i++) begin
            checks++;
            if (i >= obs_word.size() || obs_word[i] !== exp_word[i] || obs_cycle[i] != exp_cycle[i])
                $display("[TB] FAIL b2b_byte[%0d]: got %h@%0d want %h@%0d", i,
                         (i < obs_word.size()) ? obs_word[i] : 12'hxxx, (i < obs_cycle.size()) ? obs_cycle[i] : -1,
                         exp_word[i], exp_cycle[i]);
            else passed++;
        end
        checks++; if (done_cnt0 != 2 || done_cnt1 != 2 || proto_errs != 0) $display("[TB] FAIL b2b_side: got done0=%0d done1=%0d proto=%0d want 2/2/0", done_cnt0, done_cnt1, proto_errs); else passed++;
    endtask

    task automatic test_zero_length();
        bit to;
        clear_requesters();
        q_len1.push_back(0);
        build_expected();
        run_traffic(100, 0, 0, -1, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL zero_timeout: got %b want 0", to); else passed++;
        checks++; if (obs_word.size() != exp_word.size()) $display("[TB] FAIL zero_count: got %0d want %0d", obs_word.size(), exp_word.size()); else passed++;
        for (int i = 0; i < exp_word.size(); i++) begin
            checks++;
            if (i >= obs_word.size() || obs_word[i] !== exp_word[i] || obs_cycle[i] != exp_cycle[i])
                $display("[TB] FAIL zero_byte[%0d]: got %h want %h", i, (i < obs_word.size()) ? obs_word[i] : 12'hxxx, exp_word[i]);
            else passed++;
        end
        checks++; if (ready_cnt1 != 0 || done_cnt1 != 1) $display("[TB] FAIL zero_side: got ready1=%0d done1=%0d want 0/1", ready_cnt1, done_cnt1); else passed++;
    endtask

    task automatic test_stall_gap();
        bit to;
        clear_requesters();
        q_len0.push_back(16'h0102);
        for (int i = 0; i < 16'h0102; i++) q_dat0.push_back(8'($urandom));
        build_expected();
        run_traffic(5000, 1, 25, -1, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL stall_timeout: got %b want 0", to); else passed++;
        checks++; if (obs_word.size() != exp_word.size()) $display("[TB] FAIL stall_count: got %0d want %0d", obs_word.size(), exp_word.size()); else passed++;
        for (int i = 0; i < exp_word.size(); i++) begin
            checks++;
            if (i >= obs_word.size() || obs_word[i] !== exp_word[i])
                $display("[TB] FAIL stall_byte[%0d]: got %h want %h", i, (i < obs_word.size()) ? obs_word[i] : 12'hxxx, exp_word[i]);
            else passed++;
        end
        checks++; if (stall_errs != 0 || proto_errs != 0) $display("[TB] FAIL stall_protocol: got stall=%0d proto=%0d want 0/0", stall_errs, proto_errs); else passed++;
    endtask

    task automatic test_random();
        bit to;
        for (int round = 0; round < 3; round++) begin
            clear_requesters();
            for (int p = 0; p < 3; p++) begin
                int n0 = $urandom_range(0, 12);
                int n1 = $urandom_range(0, 12);
                q_len0.push_back(n0);
                q_len1.push_back(n1);
                for (int i = 0; i < n0; i++) q_dat0.push_back(8'($urandom));
                for (int i = 0; i < n1; i++) q_dat1.push_back(8'($urandom));
            end
            build_expected();
            run_traffic(3000, 2, 20, -1, to);
            checks++; if (to !== 1'b0) $display("[TB] FAIL rand%0d_timeout: got %b want 0", round, to); else passed++;
            checks++; if (obs_word.size() != exp_word.size()) $display("[TB] FAIL rand%0d_count: got %0d want %0d", round, obs_word.size(), exp_word.size()); else passed++;
            for (int i = 0; i < exp_word.size(); i++) begin
                checks++;
                if (i >= obs_word.size() || obs_word[i] !== exp_word[i])
                    $display("[TB] FAIL rand%0d_byte[%0d]: got %h want %h", round, i, (i < obs_word.size()) ? obs_word[i] : 12'hxxx, exp_word[i]);
                else passed++;
            end
            checks++; if (stall_errs != 0 || proto_errs != 0 || done_cnt0 != 3 || done_cnt1 != 3)
                $display("[TB] FAIL rand%0d_protocol: got stall=%0d proto=%0d done=%0d/%0d want 0/0/3/3", round, stall_errs, proto_errs, done_cnt0, done_cnt1);
            else passed++;
        end
    endtask

    task automatic test_abort();
        bit         to;
        logic [7:0] pkt[5];
        clear_requesters();
        q_len0.push_back(5);
        for (int i = 0; i < 5; i++) begin
            pkt[i] = 8'($urandom);
            q_dat0.push_back(pkt[i]);
        end
        run_traffic(100, 0, 0, 2, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL abort_reach_timeout: got %b want 0", to); else passed++;
        @(posedge clock); #2;
        checks++; if ({bus.busy, bus.grant, bus.out_valid} !== 4'b1011) $display("[TB] FAIL abort_pre: got %b want 1011", {bus.busy, bus.grant, bus.out_valid}); else passed++;
        clear_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.grant, bus.out_valid, bus.req0_ready} !== 5'b00000) $display("[TB] FAIL abort_now: got %b want 00000", {bus.busy, bus.grant, bus.out_valid, bus.req0_ready}); else passed++;
        clear_requesters();
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear_n = 1'b1;
        model_last = 1;
        q_len0.push_back(5);
        for (int i = 0; i < 5; i++) q_dat0.push_back(pkt[i]);
        build_expected();
        run_traffic(200, 0, 0, -1, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL abort_retry_timeout: got %b want 0", to); else passed++;
        checks++; if (obs_word.size() != exp_word.size()) $display("[TB] FAIL abort_retry_count: got %0d want %0d", obs_word.size(), exp_word.size()); else passed++;
        for (int i = 0; i < exp_word.size(); i++) begin
            checks++;
            if (i >= obs_word.size() || obs_word[i] !== exp_word[i] || obs_cycle[i] != exp_cycle[i])
                $display("[TB] FAIL abort_retry_byte[%0d]: got %h want %h", i, (i < obs_word.size()) ? obs_word[i] : 12'hxxx, exp_word[i]);
            else passed++;
        end
    endtask

    initial begin
        clear_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_length = 16'd0; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_length = 16'd0; bus.req1_data = 8'h00;
        bus.out_ready  = 1'b0;
        model_last = 1;
        idx0 = 0; idx1 = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_length();
        test_stall_gap();
        test_random();
        test_abort();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
